// File: rtl/regfile_writeback_arbiter.sv
// Write-port arbiter for the 32x32 register file: ALU results win, LSU results are queued.
// Optional forwarding of pending writes to decode when REGWB_FWD_EN is defined.
module regfile_writeback_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AW    = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alu_we,
  input  logic [AW-1:0]           alu_rd,
  input  logic [XLEN-1:0]         alu_data,
  input  logic                    lsu_valid,
  output logic                    lsu_ready,
  input  logic [AW-1:0]           lsu_rd,
  input  logic [XLEN-1:0]         lsu_data,
  output logic                    RegWrite,
  output logic [AW-1:0]           rd,
  output logic [XLEN-1:0]         WriteData,
  input  logic [AW-1:0]           rs1,
  input  logic [AW-1:0]           rs2,
  input  logic [AW-1:0]           chk_rd,
  output logic                    hazard,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    fwd1_valid,
  output logic                    fwd2_valid,
  output logic [XLEN-1:0]         fwd1_data,
  output logic [XLEN-1:0]         fwd2_data
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]   rd_mem_q   [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];

  logic            regwrite_q, regwrite_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic alu_sel, fifo_sel, byp_sel, lsu_acc, push;
  logic hit1, hit2, hitc;
`ifdef REGWB_FWD_EN
  logic [XLEN-1:0] f1d, f2d;
`endif

  assign lsu_ready  = (count_q < CW'(DEPTH));
  assign RegWrite   = regwrite_q;
  assign rd         = rd_q;
  assign WriteData  = wdata_q;
  assign fifo_count = count_q;

  // Source selection and FIFO bookkeeping; ALU > FIFO head > LSU bypass
  always_comb begin
    alu_sel    = alu_we && (alu_rd != '0);
    fifo_sel   = !alu_sel && (count_q != '0);
    lsu_acc    = lsu_valid && lsu_ready;
    byp_sel    = !alu_sel && (count_q == '0) && lsu_acc && (lsu_rd != '0);
    push       = lsu_acc && (lsu_rd != '0) && !byp_sel;
    regwrite_d = alu_sel || fifo_sel || byp_sel;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    if (alu_sel) begin
      rd_d    = alu_rd;
      wdata_d = alu_data;
    end else if (fifo_sel) begin
      rd_d    = rd_mem_q[rd_ptr_q];
      wdata_d = data_mem_q[rd_ptr_q];
    end else if (byp_sel) begin
      rd_d    = lsu_rd;
      wdata_d = lsu_data;
    end
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = fifo_sel ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(fifo_sel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage needs no reset: validity is tracked by count/pointers
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= lsu_rd;
      data_mem_q[wr_ptr_q] <= lsu_data;
    end
  end

  // Pending-write search: output reg first, then FIFO head->tail so the youngest match wins
  always_comb begin
    logic [PW-1:0] idx;
    hit1 = 1'b0;
    hit2 = 1'b0;
    hitc = 1'b0;
    idx  = '0;
`ifdef REGWB_FWD_EN
    f1d = '0;
    f2d = '0;
`endif
    if (regwrite_q) begin
      if (rd_q == rs1) begin
        hit1 = 1'b1;
`ifdef REGWB_FWD_EN
        f1d = wdata_q;
`endif
      end
      if (rd_q == rs2) begin
        hit2 = 1'b1;
`ifdef REGWB_FWD_EN
        f2d = wdata_q;
`endif
      end
      if (rd_q == chk_rd) hitc = 1'b1;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (rd_mem_q[idx] == rs1) begin
          hit1 = 1'b1;
`ifdef REGWB_FWD_EN
          f1d = data_mem_q[idx];
`endif
        end
        if (rd_mem_q[idx] == rs2) begin
          hit2 = 1'b1;
`ifdef REGWB_FWD_EN
          f2d = data_mem_q[idx];
`endif
        end
        if (rd_mem_q[idx] == chk_rd) hitc = 1'b1;
      end
    end
    hit1 = hit1 && (rs1 != '0);
    hit2 = hit2 && (rs2 != '0);
    hitc = hitc && (chk_rd != '0);
  end

`ifdef REGWB_FWD_EN
  assign fwd1_valid = hit1;
  assign fwd2_valid = hit2;
  assign fwd1_data  = hit1 ? f1d : '0;
  assign fwd2_data  = hit2 ? f2d : '0;
  assign hazard     = hitc;
`else
  assign fwd1_valid = 1'b0;
  assign fwd2_valid = 1'b0;
  assign fwd1_data  = '0;
  assign fwd2_data  = '0;
  assign hazard     = hit1 || hit2 || hitc;
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Bench for regfile_writeback_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_regfile_writeback_arbiter;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_we, lsu_valid, lsu_ready, RegWrite, hazard;
  logic [4:0]  alu_rd, lsu_rd, rd, rs1, rs2, chk_rd;
  logic [31:0] alu_data, lsu_data, WriteData, fwd1_data, fwd2_data;
  logic [2:0]  fifo_count;
  logic        fwd1_valid, fwd2_valid;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_writeback_arbiter #(.DEPTH(4), .XLEN(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_we(alu_we), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .RegWrite(RegWrite), .rd(rd), .WriteData(WriteData),
    .rs1(rs1), .rs2(rs2), .chk_rd(chk_rd), .hazard(hazard), .fifo_count(fifo_count),
    .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending LSU writes as a queue, plus the write-port contents
  typedef struct packed { logic [4:0] r; logic [31:0] d; } ent_t;
  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_rdy, m_byp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_we = 1'b0; m_rd = '0; m_data = '0;
    end else begin
      m_rdy = (q.size() < DEPTH);
      m_byp = 1'b0;
      if (alu_we && alu_rd != 0) begin
        m_we = 1'b1; m_rd = alu_rd; m_data = alu_data;
      end else if (q.size() > 0) begin
        m_we = 1'b1; m_rd = q[0].r; m_data = q[0].d;
        q.delete(0);
      end else if (lsu_valid && m_rdy && lsu_rd != 0) begin
        m_we = 1'b1; m_rd = lsu_rd; m_data = lsu_data; m_byp = 1'b1;
      end else begin
        m_we = 1'b0;
      end
      if (lsu_valid && m_rdy && lsu_rd != 0 && !m_byp) q.push_back('{r: lsu_rd, d: lsu_data});
    end
  end

  function automatic bit pend(input logic [4:0] r);
    if (r == 0) return 1'b0;
    if (m_we && m_rd == r) return 1'b1;
    foreach (q[i]) if (q[i].r == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [32:0] youngest(input logic [4:0] r);
    if (r == 0) return '0;
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].r == r) return {1'b1, q[i].d};
    if (m_we && m_rd == r) return {1'b1, m_data};
    return '0;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [32:0] y1, y2;
    y1 = youngest(rs1);
    y2 = youngest(rs2);
    chk("m_regwrite", 64'(RegWrite), 64'(m_we));
    chk("m_rd", 64'(rd), 64'(m_rd));
    chk("m_wdata", 64'(WriteData), 64'(m_data));
    chk("m_count", 64'(fifo_count), 64'(q.size()));
    chk("m_ready", 64'(lsu_ready), 64'(q.size() < DEPTH));
`ifdef REGWB_FWD_EN
    chk("m_hazard", 64'(hazard), 64'(pend(chk_rd)));
    chk("m_fwd1v", 64'(fwd1_valid), 64'(y1[32]));
    chk("m_fwd2v", 64'(fwd2_valid), 64'(y2[32]));
    if (y1[32]) chk("m_fwd1d", 64'(fwd1_data), 64'(y1[31:0]));
    if (y2[32]) chk("m_fwd2d", 64'(fwd2_data), 64'(y2[31:0]));
`else
    chk("m_hazard", 64'(hazard), 64'(pend(rs1) | pend(rs2) | pend(chk_rd)));
    chk("m_fwdv", 64'({fwd1_valid, fwd2_valid}), 64'(0));
    chk("m_fwdd", 64'({fwd1_data, fwd2_data}), 64'(0));
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    alu_we = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    rs1 = 0; rs2 = 0; chk_rd = 0;
    #7;
    chk("rst_regwrite", 64'(RegWrite), 64'(0));
    chk("rst_rd", 64'(rd), 64'(0));
    chk("rst_wdata", 64'(WriteData), 64'(0));
    chk("rst_count", 64'(fifo_count), 64'(0));
    #5;
    rst_n = 1'b1;
    chk("rst_ready", 64'(lsu_ready), 64'(1));

    // ALU write, one-cycle latency
    alu_we = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    cyc();
    chk("t1_regwrite", 64'(RegWrite), 64'(1));
    chk("t1_rd", 64'(rd), 64'(5));
    chk("t1_wdata", 64'(WriteData), 64'hDEADBEEF);
    chk("t1_count", 64'(fifo_count), 64'(0));

    // LSU bypass on empty FIFO
    alu_we = 0; lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h11;
    cyc();
    chk("t2_regwrite", 64'(RegWrite), 64'(1));
    chk("t2_rd", 64'(rd), 64'(7));
    chk("t2_wdata", 64'(WriteData), 64'h11);
    chk("t2_count", 64'(fifo_count), 64'(0));
    lsu_valid = 0;
    cyc();
    chk("t2_idle_we", 64'(RegWrite), 64'(0));
    chk("t2_idle_rd", 64'(rd), 64'(7));

    // ALU burst fills FIFO, then drains in order
    for (int k = 0; k < 6; k++) begin
      alu_we = 1; alu_rd = 5'(20 + k); alu_data = 32'(k);
      lsu_valid = (k < 4); lsu_rd = 5'(k + 1); lsu_data = 32'h100 + 32'(k + 1);
      cyc();
    end
    lsu_valid = 0;
    chk("t3_count_full", 64'(fifo_count), 64'(4));
    chk("t3_ready_full", 64'(lsu_ready), 64'(0));
    chk("t3_alu_rd", 64'(rd), 64'(25));
    alu_we = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t3_drain_we", 64'(RegWrite), 64'(1));
      chk("t3_drain_rd", 64'(rd), 64'(k + 1));
      chk("t3_drain_data", 64'(WriteData), 64'h100 + 64'(k + 1));
    end
    cyc();
    chk("t3_empty_count", 64'(fifo_count), 64'(0));
    chk("t3_empty_we", 64'(RegWrite), 64'(0));

    // Hazard / forwarding on a queued x3
    alu_we = 1; alu_rd = 9; alu_data = 32'h99;
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'hA;
    cyc();
    lsu_valid = 0;
    chk("t4_count", 64'(fifo_count), 64'(1));
    rs1 = 3;
    #1;
`ifdef REGWB_FWD_EN
    chk("t4_hazard_rs1", 64'(hazard), 64'(0));
    chk("t4_fwd1_valid", 64'(fwd1_valid), 64'(1));
    chk("t4_fwd1_data", 64'(fwd1_data), 64'hA);
`else
    chk("t4_hazard_rs1", 64'(hazard), 64'(1));
    chk("t4_fwd1_valid", 64'(fwd1_valid), 64'(0));
    chk("t4_fwd1_data", 64'(fwd1_data), 64'(0));
`endif
    rs1 = 0; chk_rd = 3;
    #1;
    chk("t4_hazard_chk", 64'(hazard), 64'(1));
    chk_rd = 9;
    #1;
    chk("t4_hazard_outreg", 64'(hazard), 64'(1));
    chk_rd = 0; alu_we = 0;
    cyc();
    chk("t4_drain_rd", 64'(rd), 64'(3));
    chk("t4_drain_data", 64'(WriteData), 64'hA);
    cyc();
    chk("t4_idle_we", 64'(RegWrite), 64'(0));

    // Writes to x0 are dropped, LSU still handshakes
    alu_we = 1; alu_rd = 0; alu_data = 32'h55;
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h66;
    #1;
    chk("t5_ready", 64'(lsu_ready), 64'(1));
    cyc();
    chk("t5_regwrite", 64'(RegWrite), 64'(0));
    chk("t5_count", 64'(fifo_count), 64'(0));
    alu_we = 0; lsu_valid = 0;
    cyc();

    // Reset mid-operation discards queued writes
    alu_we = 1; alu_rd = 9; alu_data = 32'h77;
    for (int k = 0; k < 3; k++) begin
      lsu_valid = 1; lsu_rd = 5'(11 + k); lsu_data = 32'(k + 1);
      cyc();
    end
    lsu_valid = 0;
    chk("t6_count", 64'(fifo_count), 64'(3));
    #2;
    rst_n = 0; alu_we = 0;
    #1;
    chk("t6_rst_we", 64'(RegWrite), 64'(0));
    chk("t6_rst_rd", 64'(rd), 64'(0));
    chk("t6_rst_data", 64'(WriteData), 64'(0));
    chk("t6_rst_count", 64'(fifo_count), 64'(0));
    #3;
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t6_post_we", 64'(RegWrite), 64'(0));
      chk("t6_post_count", 64'(fifo_count), 64'(0));
    end

    // Mixed traffic checked by the per-cycle model
    for (int k = 0; k < 400; k++) begin
      alu_we    = ($urandom_range(0, 9) < 4);
      alu_rd    = 5'($urandom_range(0, 31));
      alu_data  = $urandom;
      lsu_valid = ($urandom_range(0, 1) == 1);
      lsu_rd    = 5'($urandom_range(0, 15));
      lsu_data  = $urandom;
      rs1       = 5'($urandom_range(0, 15));
      rs2       = 5'($urandom_range(0, 15));
      chk_rd    = 5'($urandom_range(0, 15));
      cyc();
    end
    alu_we = 0; lsu_valid = 0;
    repeat (8) cyc();
    chk("end_count", 64'(fifo_count), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
